// File: rtl/pc_fetch_sequencer.sv
// Fetch controller around the next-PC datapath: owns the architectural PC, issues
// instruction-memory requests, hands fetched words to decode and applies branch redirects.
module pc_fetch_sequencer #(
   parameter int ADDR_W  = 64,
   parameter int INSTR_W = 32,
   parameter int CNT_W   = 32
) (
   input  logic               CLK,
   input  logic               Reset_L,
   input  logic [ADDR_W-1:0]  startPC,
   output logic               IMemReqValid,
   input  logic               IMemReqReady,
   output logic [ADDR_W-1:0]  IMemAddr,
   input  logic               IMemRspValid,
   input  logic [INSTR_W-1:0] IMemRspData,
   input  logic               Redirect,
   input  logic [ADDR_W-1:0]  RedirectPC,
   output logic               InstrValid,
   input  logic               InstrReady,
   output logic [INSTR_W-1:0] InstrOut,
   output logic [ADDR_W-1:0]  InstrPC,
   output logic [CNT_W-1:0]   InstrCount
);

   typedef enum logic [1:0] {
      S_INIT,
      S_REQ,
      S_WAIT,
      S_HOLD
   } state_t;

   state_t              state, state_nx;
   logic [ADDR_W-1:0]   pc, pc_nx;
   logic [ADDR_W-1:0]   pending_pc, pending_pc_nx;
   logic                drop_pending, drop_pending_nx;
   logic                redir_pending, redir_pending_nx;
   logic [INSTR_W-1:0]  instr_out_nx;
   logic [ADDR_W-1:0]   instr_pc_nx;
   logic [CNT_W-1:0]    instr_count_nx;

   // The request address comes straight from the PC so it cannot move while a request stalls.
   assign IMemAddr = pc;

   // NOTE: every variable gets its hold value first, so no path through the case can infer a latch.
   always_comb begin
      state_nx         = state;
      pc_nx            = pc;
      pending_pc_nx    = pending_pc;
      drop_pending_nx  = drop_pending;
      redir_pending_nx = redir_pending;
      instr_out_nx     = InstrOut;
      instr_pc_nx      = InstrPC;
      instr_count_nx   = InstrCount;

      unique case (state)
         S_INIT: begin
            pc_nx    = startPC;
            state_nx = S_REQ;
         end

         S_REQ: begin
            // A redirect cannot retract an offered request; remember it and drop the response later.
            if (Redirect) begin
               pending_pc_nx    = RedirectPC;
               redir_pending_nx = 1'b1;
            end
            if (IMemReqReady) begin
               state_nx = S_WAIT;
               if (Redirect || redir_pending) begin
                  drop_pending_nx = 1'b1;
               end
            end
         end

         S_WAIT: begin
            if (IMemRspValid) begin
               if (Redirect) begin
                  pc_nx            = RedirectPC;
                  drop_pending_nx  = 1'b0;
                  redir_pending_nx = 1'b0;
                  state_nx         = S_REQ;
               end else if (drop_pending) begin
                  pc_nx            = pending_pc;
                  drop_pending_nx  = 1'b0;
                  redir_pending_nx = 1'b0;
                  state_nx         = S_REQ;
               end else begin
                  instr_out_nx = IMemRspData;
                  instr_pc_nx  = pc;
                  state_nx     = S_HOLD;
               end
            end else if (Redirect) begin
               drop_pending_nx = 1'b1;
               pending_pc_nx   = RedirectPC;
            end
         end

         S_HOLD: begin
            // Redirect wins over the decode handshake: the held word is flushed uncounted.
            if (Redirect) begin
               pc_nx    = RedirectPC;
               state_nx = S_REQ;
            end else if (InstrReady) begin
               pc_nx          = pc + ADDR_W'(4);
               instr_count_nx = InstrCount + CNT_W'(1);
               state_nx       = S_REQ;
            end
         end

         default: state_nx = S_INIT;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         state         <= S_INIT;
         pc            <= '0;
         pending_pc    <= '0;
         drop_pending  <= 1'b0;
         redir_pending <= 1'b0;
         IMemReqValid  <= 1'b0;
         InstrValid    <= 1'b0;
         InstrOut      <= '0;
         InstrPC       <= '0;
         InstrCount    <= '0;
      end else begin
         state         <= state_nx;
         pc            <= pc_nx;
         pending_pc    <= pending_pc_nx;
         drop_pending  <= drop_pending_nx;
         redir_pending <= redir_pending_nx;
         IMemReqValid  <= (state_nx == S_REQ);
         InstrValid    <= (state_nx == S_HOLD);
         InstrOut      <= instr_out_nx;
         InstrPC       <= instr_pc_nx;
         InstrCount    <= instr_count_nx;
      end
   end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed scenarios plus a randomized run,
// checked by a monitor against an instruction-stream model kept in a queue.
module tb_pc_fetch_sequencer;

   localparam int ADDR_W  = 64;
   localparam int INSTR_W = 32;
   localparam int CNT_W   = 32;

   logic               CLK;
   logic               Reset_L;
   logic [ADDR_W-1:0]  startPC;
   logic               IMemReqValid;
   logic               IMemReqReady;
   logic [ADDR_W-1:0]  IMemAddr;
   logic               IMemRspValid;
   logic [INSTR_W-1:0] IMemRspData;
   logic               Redirect;
   logic [ADDR_W-1:0]  RedirectPC;
   logic               InstrValid;
   logic               InstrReady;
   logic [INSTR_W-1:0] InstrOut;
   logic [ADDR_W-1:0]  InstrPC;
   logic [CNT_W-1:0]   InstrCount;

   pc_fetch_sequencer #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W),
      .CNT_W   (CNT_W)
   ) dut (
      .CLK          (CLK),
      .Reset_L      (Reset_L),
      .startPC      (startPC),
      .IMemReqValid (IMemReqValid),
      .IMemReqReady (IMemReqReady),
      .IMemAddr     (IMemAddr),
      .IMemRspValid (IMemRspValid),
      .IMemRspData  (IMemRspData),
      .Redirect     (Redirect),
      .RedirectPC   (RedirectPC),
      .InstrValid   (InstrValid),
      .InstrReady   (InstrReady),
      .InstrOut     (InstrOut),
      .InstrPC      (InstrPC),
      .InstrCount   (InstrCount)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: the next instruction decode should see, and how many were delivered.
   logic [ADDR_W-1:0] exp_q[$];
   logic [CNT_W-1:0]  exp_cnt;
   logic [ADDR_W-1:0] acc_log[$];
   int                del_cnt = 0;
   logic [ADDR_W-1:0] last_del_pc;

   // Memory model: one outstanding request, answered after slot_cnt cycles.
   bit                rnd_mode = 1'b0;
   int                mem_lat  = 1;
   bit                slot_busy = 1'b0;
   int                slot_cnt;
   logic [ADDR_W-1:0] slot_addr;

   function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
      return a[31:0] ^ a[63:32] ^ 32'hC3A5_5A3C ^ {a[15:0], a[31:16]};
   endfunction

   function automatic logic [ADDR_W-1:0] acc_at(input int i);
      return (i < acc_log.size()) ? acc_log[i] : 64'hDEAD_DEAD_DEAD_DEAD;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: samples at the falling edge, i.e. what the next rising edge will act on.
   bit                saw_rst = 1'b1;
   int                since_rel = 0;
   bit                prev_stall = 1'b0;
   logic [ADDR_W-1:0] prev_addr;
   bit                prev_hold = 1'b0;
   logic [ADDR_W-1:0] prev_ipc;
   logic [INSTR_W-1:0] prev_iout;

   initial begin : monitor
      logic [ADDR_W-1:0] e;
      forever begin
         @(negedge CLK);
         if (!Reset_L) begin
            exp_q.delete();
            exp_q.push_back(startPC);
            exp_cnt    = '0;
            slot_busy  = 1'b0;
            saw_rst    = 1'b1;
            since_rel  = 0;
            prev_stall = 1'b0;
            prev_hold  = 1'b0;
         end else begin
            if (saw_rst) begin
               check("init_no_req", IMemReqValid, 0);
               check("init_no_instr", InstrValid, 0);
            end else if (since_rel == 1) begin
               check("first_req_valid", IMemReqValid, 1);
               check("first_req_addr", IMemAddr, startPC);
            end
            if (prev_stall) begin
               check("stall_valid", IMemReqValid, 1);
               check("stall_addr", IMemAddr, prev_addr);
            end
            if (prev_hold) begin
               check("hold_valid", InstrValid, 1);
               check("hold_pc", InstrPC, prev_ipc);
               check("hold_data", InstrOut, prev_iout);
            end
            check("req_instr_exclusive", IMemReqValid && InstrValid, 0);

            if (InstrValid && InstrReady && !Redirect) begin
               check("model_has_entry", exp_q.size(), 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("deliver_pc", InstrPC, e);
                  check("deliver_data", InstrOut, mem_word(e));
                  check("deliver_count", InstrCount, exp_cnt);
                  exp_cnt = exp_cnt + 1;
                  exp_q.push_back(e + 64'd4);
               end
               del_cnt++;
               last_del_pc = InstrPC;
            end
            if (Redirect && !saw_rst) begin
               exp_q.delete();
               exp_q.push_back(RedirectPC);
            end

            if (IMemReqValid && IMemReqReady) begin
               acc_log.push_back(IMemAddr);
               slot_busy = 1'b1;
               slot_addr = IMemAddr;
               slot_cnt  = rnd_mode ? int'($urandom_range(1, 3)) : mem_lat;
            end
            prev_stall = IMemReqValid && !IMemReqReady;
            prev_addr  = IMemAddr;
            prev_hold  = InstrValid && !InstrReady && !Redirect;
            prev_ipc   = InstrPC;
            prev_iout  = InstrOut;
            saw_rst    = 1'b0;
            since_rel++;
         end
      end
   end

   // Advance one clock and drive this cycle's inputs just after the edge.
   task automatic cycle();
      @(posedge CLK);
      #1;
      Redirect     = 1'b0;
      IMemRspValid = 1'b0;
      if (slot_busy) begin
         if (slot_cnt <= 1) begin
            IMemRspValid = 1'b1;
            IMemRspData  = mem_word(slot_addr);
            slot_busy    = 1'b0;
         end else begin
            slot_cnt--;
         end
      end
      if (rnd_mode) begin
         IMemReqReady = ($urandom_range(0, 3) != 0);
         InstrReady   = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 11) == 0) begin
            Redirect   = 1'b1;
            RedirectPC = {$urandom, $urandom};
         end
      end
   endtask

   // Called just after a rising edge; asserts reset mid-cycle and releases after the next edge.
   task automatic do_reset(input logic [ADDR_W-1:0] spc);
      #2;
      Reset_L      = 1'b0;
      startPC      = spc;
      Redirect     = 1'b0;
      IMemRspValid = 1'b0;
      IMemReqReady = 1'b1;
      InstrReady   = 1'b1;
      #1;
      check("rst_req_valid", IMemReqValid, 0);
      check("rst_addr", IMemAddr, 0);
      check("rst_instr_valid", InstrValid, 0);
      check("rst_instr_out", InstrOut, 0);
      check("rst_instr_pc", InstrPC, 0);
      check("rst_count", InstrCount, 0);
      @(posedge CLK);
      #2;
      Reset_L = 1'b1;
      acc_log.delete();
   endtask

   task automatic wait_acc(input int n);
      int b = 0;
      while (acc_log.size() < n && b < 200) begin
         cycle();
         b++;
      end
      check("wait_acc_timeout", acc_log.size() >= n, 1);
   endtask

   task automatic wait_del(input int n);
      int b = 0;
      while (del_cnt < n && b < 200) begin
         cycle();
         b++;
      end
      check("wait_del_timeout", del_cnt >= n, 1);
   endtask

   task automatic wait_ivalid();
      int b = 0;
      while (!InstrValid && b < 200) begin
         cycle();
         b++;
      end
      check("wait_ivalid_timeout", InstrValid, 1);
   endtask

   initial begin : stimulus
      int d0;
      Reset_L      = 1'b0;
      startPC      = '0;
      IMemReqReady = 1'b0;
      IMemRspValid = 1'b0;
      IMemRspData  = '0;
      Redirect     = 1'b0;
      RedirectPC   = '0;
      InstrReady   = 1'b0;
      cycle();

      // Straight-line fetch at full rate.
      do_reset(64'h1000);
      mem_lat = 1;
      d0 = del_cnt;
      wait_del(d0 + 3);
      check("t1_addr0", acc_at(0), 64'h1000);
      check("t1_addr1", acc_at(1), 64'h1004);
      check("t1_addr2", acc_at(2), 64'h1008);
      check("t1_last_pc", last_del_pc, 64'h1008);
      check("t1_count", InstrCount, 3);

      // Decode back-pressure holds the instruction and stops fetching.
      do_reset(64'h1000);
      InstrReady = 1'b0;
      wait_ivalid();
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("t2_valid", InstrValid, 1);
         check("t2_no_req", IMemReqValid, 0);
         check("t2_pc", InstrPC, 64'h1000);
         check("t2_data", InstrOut, mem_word(64'h1000));
         check("t2_one_fetch", acc_log.size(), 1);
      end
      InstrReady = 1'b1;
      wait_acc(2);
      check("t2_next_addr", acc_at(1), 64'h1004);
      check("t2_count", InstrCount, 1);

      // Redirect while waiting for the 0x1004 response.
      do_reset(64'h1000);
      mem_lat = 3;
      d0 = del_cnt;
      wait_acc(2);
      Redirect   = 1'b1;
      RedirectPC = 64'h2000;
      wait_del(d0 + 2);
      check("t3_redirect_addr", acc_at(2), 64'h2000);
      check("t3_last_pc", last_del_pc, 64'h2000);

      // Redirect during a stalled request.
      do_reset(64'h1000);
      mem_lat = 1;
      IMemReqReady = 1'b0;
      d0 = del_cnt;
      cycle();
      check("t4_addr_c1", IMemAddr, 64'h1000);
      cycle();
      Redirect   = 1'b1;
      RedirectPC = 64'h3000;
      check("t4_addr_c2", IMemAddr, 64'h1000);
      cycle();
      check("t4_addr_c3", IMemAddr, 64'h1000);
      check("t4_valid_c3", IMemReqValid, 1);
      IMemReqReady = 1'b1;
      wait_del(d0 + 1);
      check("t4_first_acc", acc_at(0), 64'h1000);
      check("t4_second_acc", acc_at(1), 64'h3000);
      check("t4_last_pc", last_del_pc, 64'h3000);

      // Redirect in the same cycle as the decode handshake.
      do_reset(64'h1000);
      InstrReady = 1'b0;
      wait_ivalid();
      cycle();
      InstrReady = 1'b1;
      Redirect   = 1'b1;
      RedirectPC = 64'h1008;
      d0 = del_cnt;
      cycle();
      check("t5_flush_count", InstrCount, 0);
      check("t5_flush_valid", InstrValid, 0);
      wait_del(d0 + 1);
      check("t5_next_addr", acc_at(1), 64'h1008);
      check("t5_last_pc", last_del_pc, 64'h1008);
      check("t5_count", InstrCount, 1);

      // PC wrap, then reset in the middle of a WAIT.
      do_reset(64'hFFFF_FFFF_FFFF_FFFC);
      mem_lat = 1;
      wait_acc(2);
      check("t6_wrap_addr", acc_at(1), 64'h0);
      mem_lat = 3;
      wait_acc(3);
      do_reset(64'hFFFF_FFFF_FFFF_FFFC);
      check("t6_init_no_req", IMemReqValid, 0);
      cycle();
      check("t6_req_after_init", IMemReqValid, 1);
      check("t6_req_addr", IMemAddr, 64'hFFFF_FFFF_FFFF_FFFC);

      // Randomized traffic, redirects and back-pressure.
      do_reset({$urandom, $urandom} & ~64'h3);
      d0 = del_cnt;
      rnd_mode = 1'b1;
      repeat (3000) cycle();
      rnd_mode = 1'b0;
      check("rnd_progress", del_cnt > d0 + 50, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
